// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the EX-stage resolved-branch package and BTB line layout.
package pipeline_pkg;

    // Resolved branch/jump information emitted by the execute-stage ALU.
    typedef struct packed {
        logic [31:0] br_update_pc;
        logic        br_update_en;
        logic [31:0] br_pc_plus4;
        logic        br_valid;
        logic [31:0] br_target;
        logic        br_taken;
        logic        br_already_predicted;
    } branch_t;

    // One BTB line. The tag field is held at full width; the unused upper bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    localparam logic [1:0] CTR_WEAK_T   = 2'b10;
    localparam logic [1:0] CTR_STRONG_T = 2'b11;

endpackage

// File: rtl/sat_counter_2bit.sv
// 2-bit saturating direction counter: next state from current state and outcome.
module sat_counter_2bit
    import pipeline_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    // Step toward strong-taken on taken, toward strong-not-taken otherwise; clamp at the ends.
    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_STRONG_T) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != 2'b00) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, trained from EX.
module branch_predictor
    import pipeline_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_fetch_pc,
    input  branch_t          i_alu_prd_pkg,
    output logic [31:0]      o_next_pc,
    output logic             o_predicted_instr,
    output logic             o_mispredict,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);

    localparam int unsigned IDX_W  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_SH = IDX_W + 2;

    logic        valid_q  [BTB_ENTRIES];
    logic        valid_d  [BTB_ENTRIES];
    logic [1:0]  ctr_q    [BTB_ENTRIES];
    logic [1:0]  ctr_d    [BTB_ENTRIES];
    logic [31:0] tag_q    [BTB_ENTRIES];
    logic [31:0] tag_d    [BTB_ENTRIES];
    logic [31:0] target_q [BTB_ENTRIES];
    logic [31:0] target_d [BTB_ENTRIES];

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    branch_t          br;
    btb_entry_t       f_entry, u_entry;
    logic [IDX_W-1:0] f_idx, u_idx;
    logic [31:0]      f_tag, u_tag;
    logic             f_hit, u_hit, upd, mismatch, mispredict;
    logic [1:0]       u_ctr_next;
    logic             unused_pc_lsbs;

    sat_counter_2bit u_sat (
        .i_ctr   (u_entry.ctr),
        .i_taken (br.br_taken),
        .o_ctr   (u_ctr_next)
    );

    // Lookup on the fetch PC and on the EX update PC; both read pre-update table contents.
    always_comb begin
        br             = i_alu_prd_pkg;
        unused_pc_lsbs = ^{i_fetch_pc[1:0], br.br_update_pc[1:0]};

        f_idx          = i_fetch_pc[IDX_W+1:2];
        f_tag          = i_fetch_pc >> TAG_SH;
        f_entry.valid  = valid_q[f_idx];
        f_entry.tag    = tag_q[f_idx];
        f_entry.target = target_q[f_idx];
        f_entry.ctr    = ctr_q[f_idx];
        f_hit          = f_entry.valid && (f_entry.tag == f_tag);

        u_idx          = br.br_update_pc[IDX_W+1:2];
        u_tag          = br.br_update_pc >> TAG_SH;
        u_entry.valid  = valid_q[u_idx];
        u_entry.tag    = tag_q[u_idx];
        u_entry.target = target_q[u_idx];
        u_entry.ctr    = ctr_q[u_idx];
        u_hit          = u_entry.valid && (u_entry.tag == u_tag);
    end

    // Prediction and misprediction detection, purely combinational.
    always_comb begin
        upd      = br.br_valid && br.br_update_en;
        mismatch = (br.br_already_predicted != br.br_taken) ||
                   (br.br_already_predicted && br.br_taken &&
                    !(u_hit && (u_entry.target == br.br_target)));
        // Held low while reset is asserted so no flush escapes during reset.
        mispredict        = i_rst_n && upd && mismatch;
        o_predicted_instr = f_hit && f_entry.ctr[1];
        o_next_pc         = o_predicted_instr ? f_entry.target : i_fetch_pc + 32'd4;
        o_mispredict      = mispredict;
        o_redirect_pc     = br.br_taken ? br.br_target : br.br_pc_plus4;
        o_br_count        = br_cnt_q;
        o_mispred_count   = mis_cnt_q;
    end

    // Next-state of the table and performance counters for a single update per cycle.
    always_comb begin
        valid_d   = valid_q;
        ctr_d     = ctr_q;
        tag_d     = tag_q;
        target_d  = target_q;
        br_cnt_d  = br_cnt_q + (upd ? CNT_W'(1) : '0);
        mis_cnt_d = mis_cnt_q + (mispredict ? CNT_W'(1) : '0);
        if (upd) begin
            if (u_hit) begin
                ctr_d[u_idx] = u_ctr_next;
                if (br.br_taken) target_d[u_idx] = br.br_target;
            end else if (br.br_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = br.br_target;
                ctr_d[u_idx]    = CTR_WEAK_T;
            end
        end
    end

    // Valid bits, counters and perf counters: asynchronously cleared.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctr_q     <= ctr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Tag and target storage carries no reset; it is qualified by the valid bit.
    always_ff @(posedge i_clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural BTB model.
module tb_branch_predictor;
    import pipeline_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_fetch_pc;
    branch_t     i_alu_prd_pkg;
    logic [31:0] o_next_pc;
    logic        o_predicted_instr;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    int tests;
    int fails;

    branch_predictor #(.BTB_ENTRIES(32), .CNT_W(32)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_fetch_pc        (i_fetch_pc),
        .i_alu_prd_pkg     (i_alu_prd_pkg),
        .o_next_pc         (o_next_pc),
        .o_predicted_instr (o_predicted_instr),
        .o_mispredict      (o_mispredict),
        .o_redirect_pc     (o_redirect_pc),
        .o_br_count        (o_br_count),
        .o_mispred_count   (o_mispred_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    // Each line remembers the full branch PC it was allocated for; strength is an int 0..3.
    bit          m_valid [32];
    int unsigned m_pc    [32];
    int unsigned m_tgt   [32];
    int          m_str   [32];
    int unsigned m_br, m_mis;

    function automatic int unsigned m_line(input logic [31:0] pc);
        return (pc / 4) % 32;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int unsigned l = m_line(pc);
        return m_valid[l] && (m_pc[l] / 128 == pc / 128);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_str[m_line(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[m_line(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_misp(input branch_t p);
        if (!(p.br_valid && p.br_update_en)) return 1'b0;
        if (p.br_already_predicted != p.br_taken) return 1'b1;
        if (p.br_taken && !(m_hit(p.br_update_pc) && m_tgt[m_line(p.br_update_pc)] == p.br_target))
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_str[i]   = 0;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic m_train(input branch_t p);
        int unsigned l;
        if (!(p.br_valid && p.br_update_en)) return;
        l = m_line(p.br_update_pc);
        m_br++;
        if (m_misp(p)) m_mis++;
        if (m_hit(p.br_update_pc)) begin
            if (p.br_taken) begin
                m_str[l] = (m_str[l] == 3) ? 3 : m_str[l] + 1;
                m_tgt[l] = p.br_target;
            end else begin
                m_str[l] = (m_str[l] == 0) ? 0 : m_str[l] - 1;
            end
        end else if (p.br_taken) begin
            m_valid[l] = 1'b1;
            m_pc[l]    = p.br_update_pc;
            m_tgt[l]   = p.br_target;
            m_str[l]   = 2;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic branch_t mk(input logic [31:0] upc, input logic en, input logic vld,
                                   input logic taken, input logic [31:0] tgt, input logic ap);
        branch_t p;
        p.br_update_pc         = upc;
        p.br_update_en         = en;
        p.br_pc_plus4          = upc + 32'd4;
        p.br_valid             = vld;
        p.br_target            = tgt;
        p.br_taken             = taken;
        p.br_already_predicted = ap;
        return p;
    endfunction

    function automatic branch_t idle();
        return mk(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endfunction

    // Apply inputs just after a falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic [31:0] pc, input branch_t p);
        @(negedge i_clk);
        i_fetch_pc    = pc;
        i_alu_prd_pkg = p;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        branch_t p;
        i_rst_n = 1'b0;
        m_reset();
        drive(32'h100, idle());
        tests++; if (o_next_pc !== 32'h104) begin fails++; $display("FAIL reset_next_pc got=%h exp=%h", o_next_pc, 32'h104); end
        tests++; if (o_predicted_instr !== 1'b0) begin fails++; $display("FAIL reset_pred got=%b exp=0", o_predicted_instr); end
        tests++; if (o_mispredict !== 1'b0) begin fails++; $display("FAIL reset_misp got=%b exp=0", o_mispredict); end
        tests++; if (o_br_count !== 32'd0) begin fails++; $display("FAIL reset_br_count got=%0d exp=0", o_br_count); end
        tests++; if (o_mispred_count !== 32'd0) begin fails++; $display("FAIL reset_mis_count got=%0d exp=0", o_mispred_count); end
        p = mk(32'h200, 1'b1, 1'b1, 1'b1, 32'h280, 1'b0);
        drive(32'h200, p);
        tests++; if (o_mispredict !== 1'b0) begin fails++; $display("FAIL reset_misp_gated got=%b exp=0", o_mispredict); end
        tests++; if (o_redirect_pc !== 32'h280) begin fails++; $display("FAIL reset_redirect got=%h exp=%h", o_redirect_pc, 32'h280); end
        drive(32'h200, idle());
        tests++; if (o_predicted_instr !== 1'b0 || o_br_count !== 32'd0) begin fails++; $display("FAIL reset_no_train pred=%b cnt=%0d exp pred=0 cnt=0", o_predicted_instr, o_br_count); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_cold_taken();
        branch_t p = mk(32'h200, 1'b1, 1'b1, 1'b1, 32'h280, 1'b0);
        drive(32'h100, p);
        tests++; if (o_mispredict !== 1'b1) begin fails++; $display("FAIL cold_misp got=%b exp=1", o_mispredict); end
        tests++; if (o_redirect_pc !== 32'h280) begin fails++; $display("FAIL cold_redirect got=%h exp=%h", o_redirect_pc, 32'h280); end
        m_train(p);
        drive(32'h200, idle());
        tests++; if (o_predicted_instr !== 1'b1) begin fails++; $display("FAIL cold_pred got=%b exp=1", o_predicted_instr); end
        tests++; if (o_next_pc !== 32'h280) begin fails++; $display("FAIL cold_next_pc got=%h exp=%h", o_next_pc, 32'h280); end
        tests++; if (o_mispred_count !== 32'd1 || o_br_count !== 32'd1) begin fails++; $display("FAIL cold_counts mis=%0d br=%0d exp mis=1 br=1", o_mispred_count, o_br_count); end
    endtask

    task automatic test_counter_walk();
        // Strength path from weak-T: NT->01, T->10, T->11, T->11, NT->10, NT->01.
        bit   exp_pred [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit   tk       [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        branch_t p = mk(32'h200, 1'b1, 1'b1, 1'b0, 32'h280, 1'b1);
        drive(32'h0, p);
        tests++; if (o_mispredict !== 1'b1) begin fails++; $display("FAIL walk_nt_misp got=%b exp=1", o_mispredict); end
        tests++; if (o_redirect_pc !== 32'h204) begin fails++; $display("FAIL walk_nt_redirect got=%h exp=%h", o_redirect_pc, 32'h204); end
        m_train(p);
        for (int i = 0; i < 6; i++) begin
            p = (i < 5) ? mk(32'h200, 1'b1, 1'b1, tk[i], 32'h280, exp_pred[i]) : idle();
            drive(32'h200, p);
            tests++; if (o_predicted_instr !== exp_pred[i]) begin fails++; $display("FAIL walk_pred step=%0d got=%b exp=%b", i, o_predicted_instr, exp_pred[i]); end
            tests++; if (o_next_pc !== (exp_pred[i] ? 32'h280 : 32'h204)) begin fails++; $display("FAIL walk_next_pc step=%0d got=%h", i, o_next_pc); end
            if (i < 5) begin
                tests++; if (o_mispredict !== (exp_pred[i] != tk[i])) begin fails++; $display("FAIL walk_misp step=%0d got=%b exp=%b", i, o_mispredict, exp_pred[i] != tk[i]); end
            end
            m_train(p);
        end
    endtask

    task automatic test_jalr_target();
        branch_t p = mk(32'h300, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0);
        drive(32'h0, p);
        m_train(p);
        p = mk(32'h300, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1);
        drive(32'h300, p);
        tests++; if (o_next_pc !== 32'h400) begin fails++; $display("FAIL jalr_old_target got=%h exp=%h", o_next_pc, 32'h400); end
        tests++; if (o_mispredict !== 1'b1) begin fails++; $display("FAIL jalr_misp got=%b exp=1", o_mispredict); end
        tests++; if (o_redirect_pc !== 32'h500) begin fails++; $display("FAIL jalr_redirect got=%h exp=%h", o_redirect_pc, 32'h500); end
        m_train(p);
        drive(32'h300, idle());
        tests++; if (o_next_pc !== 32'h500) begin fails++; $display("FAIL jalr_new_target got=%h exp=%h", o_next_pc, 32'h500); end
    endtask

    task automatic test_alias_collision();
        branch_t p = mk(32'h1000, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0);
        drive(32'h0, p);
        m_train(p);
        drive(32'h1080, idle());
        tests++; if (o_predicted_instr !== 1'b0 || o_next_pc !== 32'h1084) begin fails++; $display("FAIL alias_miss pred=%b next=%h exp pred=0 next=%h", o_predicted_instr, o_next_pc, 32'h1084); end
        p = mk(32'h1080, 1'b1, 1'b1, 1'b1, 32'h3000, 1'b0);
        drive(32'h1000, p);
        tests++; if (o_next_pc !== 32'h2000 || o_predicted_instr !== 1'b1) begin fails++; $display("FAIL collision_preupdate next=%h pred=%b exp next=%h pred=1", o_next_pc, o_predicted_instr, 32'h2000); end
        tests++; if (o_mispredict !== 1'b1) begin fails++; $display("FAIL collision_misp got=%b exp=1", o_mispredict); end
        m_train(p);
        drive(32'h1000, idle());
        tests++; if (o_next_pc !== 32'h1004) begin fails++; $display("FAIL alias_evicted got=%h exp=%h", o_next_pc, 32'h1004); end
        drive(32'h1080, idle());
        tests++; if (o_next_pc !== 32'h3000) begin fails++; $display("FAIL alias_new_owner got=%h exp=%h", o_next_pc, 32'h3000); end
    endtask

    task automatic test_gating();
        branch_t p;
        int unsigned br0 = m_br, mis0 = m_mis;
        p = mk(32'h1080, 1'b0, 1'b1, 1'b0, 32'h7770, 1'b1);
        drive(32'h1080, p);
        tests++; if (o_mispredict !== 1'b0) begin fails++; $display("FAIL gate_en_misp got=%b exp=0", o_mispredict); end
        p = mk(32'h1080, 1'b1, 1'b0, 1'b1, 32'h7770, 1'b0);
        drive(32'h1080, p);
        tests++; if (o_mispredict !== 1'b0) begin fails++; $display("FAIL gate_valid_misp got=%b exp=0", o_mispredict); end
        p = mk(32'h1100, 1'b0, 1'b0, 1'b1, 32'h7770, 1'b0);
        drive(32'h1080, p);
        drive(32'h1100, idle());
        tests++; if (o_predicted_instr !== 1'b0) begin fails++; $display("FAIL gate_no_alloc got=%b exp=0", o_predicted_instr); end
        drive(32'h1080, idle());
        tests++; if (o_next_pc !== 32'h3000 || o_predicted_instr !== 1'b1) begin fails++; $display("FAIL gate_table_kept next=%h pred=%b exp next=%h pred=1", o_next_pc, o_predicted_instr, 32'h3000); end
        tests++; if (o_br_count !== br0 || o_mispred_count !== mis0) begin fails++; $display("FAIL gate_counts br=%0d mis=%0d exp br=%0d mis=%0d", o_br_count, o_mispred_count, br0, mis0); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        branch_t p;
        logic [31:0] fpc, upc;
        for (int i = 0; i < 8; i++) pool[i] = 32'h8000 + 32'($urandom_range(0, 1023)) * 4;
        for (int n = 0; n < 600; n++) begin
            fpc = 32'($urandom_range(0, 63)) * 4 + ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
            upc = ($urandom_range(0, 3) == 0) ? fpc
                  : 32'($urandom_range(0, 63)) * 4 + ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
            p = mk(upc, $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                   1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 1'b0);
            p.br_already_predicted = ($urandom_range(0, 3) != 0) ? m_pred(upc) : 1'($urandom_range(0, 1));
            drive(fpc, p);
            tests++; if (o_next_pc !== m_next(fpc)) begin fails++; $display("FAIL rnd_next_pc n=%0d pc=%h got=%h exp=%h", n, fpc, o_next_pc, m_next(fpc)); end
            tests++; if (o_predicted_instr !== m_pred(fpc)) begin fails++; $display("FAIL rnd_pred n=%0d got=%b exp=%b", n, o_predicted_instr, m_pred(fpc)); end
            tests++; if (o_mispredict !== m_misp(p)) begin fails++; $display("FAIL rnd_misp n=%0d got=%b exp=%b", n, o_mispredict, m_misp(p)); end
            tests++; if (o_redirect_pc !== (p.br_taken ? p.br_target : upc + 32'd4)) begin fails++; $display("FAIL rnd_redirect n=%0d got=%h", n, o_redirect_pc); end
            tests++; if (o_br_count !== m_br || o_mispred_count !== m_mis) begin fails++; $display("FAIL rnd_counts n=%0d br=%0d mis=%0d exp br=%0d mis=%0d", n, o_br_count, o_mispred_count, m_br, m_mis); end
            m_train(p);
        end
    endtask

    task automatic test_reset_mid();
        branch_t p = mk(32'h200, 1'b1, 1'b1, 1'b1, 32'h240, m_pred(32'h200));
        drive(32'h0, p);
        m_train(p);
        drive(32'h200, idle());
        tests++; if (o_predicted_instr !== 1'b1) begin fails++; $display("FAIL midrst_pre_hit got=%b exp=1", o_predicted_instr); end
        i_rst_n = 1'b0;
        #1;
        m_reset();
        tests++; if (o_predicted_instr !== 1'b0 || o_next_pc !== 32'h204) begin fails++; $display("FAIL midrst_hit_gone pred=%b next=%h exp pred=0 next=%h", o_predicted_instr, o_next_pc, 32'h204); end
        tests++; if (o_br_count !== 32'd0 || o_mispred_count !== 32'd0) begin fails++; $display("FAIL midrst_counts br=%0d mis=%0d exp 0 0", o_br_count, o_mispred_count); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(32'h200, idle());
        tests++; if (o_predicted_instr !== 1'b0 || o_br_count !== 32'd0) begin fails++; $display("FAIL midrst_after pred=%b br=%0d exp pred=0 br=0", o_predicted_instr, o_br_count); end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        i_rst_n       = 1'b0;
        i_fetch_pc    = 32'h0;
        i_alu_prd_pkg = idle();
        test_reset();
        test_cold_taken();
        test_counter_walk();
        test_jalr_target();
        test_alias_collision();
        test_gating();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch prediction unit. It is the consumer of the branch_t update package that the execute-stage ALU emits.
- Each cycle it predicts the next fetch PC from a direct-mapped BTB with 2-bit saturating counters.
- When a resolved branch or jump arrives from EX, it trains the table and detects mispredictions.
- On a misprediction it raises a redirect (flush) back to fetch.

Parameters:
- BTB_ENTRIES, 32, number of BTB lines; power of two, ≥2; IDX_W = log2(BTB_ENTRIES).
- CNT_W, 32, width of the resolved-branch and mispredict performance counters.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_fetch_pc  input  32  PC currently being fetched.
- i_alu_prd_pkg  input  branch_t  resolved-branch package from EX. Fields: br_update_pc, br_update_en, br_pc_plus4, br_valid, br_target, br_taken, br_already_predicted.
- o_next_pc  output  32  predicted next fetch PC.
- o_predicted_instr  output  1  fetch PC hit and was predicted taken; travels down the pipe and returns as br_already_predicted.
- o_mispredict  output  1  flush request to IF/ID/EX.
- o_redirect_pc  output  32  correct PC when o_mispredict=1.
- o_br_count  output  CNT_W  number of resolved branches/jumps.
- o_mispred_count  output  CNT_W  number of mispredictions.

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Entry contents: valid, tag, target[31:0], ctr[1:0] (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Reset (async, i_rst_n=0):
  - all valid bits cleared, all ctr=00, both perf counters=0.
  - target/tag storage need not be reset.
  - Outputs during reset:
    - o_mispredict=0.
    - o_predicted_instr=0.
    - o_next_pc=i_fetch_pc+4, since the table is empty.
    - o_redirect_pc = the combinational value below.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - o_predicted_instr = hit && ctr[1].
  - o_next_pc = o_predicted_instr ? target[idx] : i_fetch_pc+4.
- Update event: upd = br_valid && br_update_en. Non-branch instructions and invalidated slots cause no table change and no counting.
- Resolution (combinational from the package, same cycle as the EX result):
  - o_redirect_pc = br_taken ? br_target : br_pc_plus4.
  - o_mispredict = upd && mismatch, where mismatch is any of:
    - br_already_predicted != br_taken;
    - br_already_predicted && br_taken && !(uhit && target[uidx]==br_target). This catches a changed JALR target or an entry evicted meanwhile.
  - uidx/uhit are the index and hit computed on br_update_pc.
- Training (clocked, on upd):
  - Hit, taken: ctr saturating +1; target ← br_target.
  - Hit, not taken: ctr saturating -1; target unchanged.
  - Miss, taken: allocate/overwrite the line. valid=1, tag, target=br_target, ctr=10.
  - Miss, not taken: no allocation.
- Perf counters:
  - o_br_count += 1 on upd.
  - o_mispred_count += 1 on o_mispredict.
  - Both wrap modulo 2^CNT_W.
- Simultaneous events:
  - Lookup and training to the same idx in one cycle: lookup returns the pre-update contents. There is no write-through bypass.
  - Only one update per cycle.
  - Mispredict does not clear the table.
- Reset assertion mid-operation discards all state immediately. No pending writes survive.
- Saturation: 11 stays 11 on taken; 00 stays 00 on not taken.

Decomposition:
- branch_t already lives in pipeline_pkg.
- Add to pipeline_pkg:
  - btb_entry_t (valid, tag, target, ctr);
  - localparams CTR_WEAK_T=2'b10 and CTR_STRONG_T=2'b11.
- One sub-module is natural: sat_counter_2bit (current ctr, taken → next ctr). It is instantiated once, on the update path.
- The table is a flop array. Async reset applies only to valid/ctr.

Test Plan:
- Reset, then i_fetch_pc=0x100 → o_next_pc=0x104, o_predicted_instr=0, o_mispredict=0, counters=0.
- Cold taken branch:
  - Stimulus: upd with pc=0x200, taken=1, target=0x280, already_predicted=0.
  - Same cycle: o_mispredict=1, o_redirect_pc=0x280.
  - Next cycle, fetch 0x200: o_predicted_instr=1, o_next_pc=0x280; o_mispred_count=1.
- Counter walk:
  - Stimulus: the 0x200 entry (ctr=10) gets not-taken, pc_plus4=0x204, already_predicted=1.
  - Response: mispredict, redirect=0x204, ctr=01; fetch 0x200 now predicts 0x204.
  - Then three taken updates → ctr 10, 11, 11 (saturation checked).
- JALR target change:
  - Stimulus: entry at 0x300 with target 0x400; update with taken=1, already_predicted=1, br_target=0x500.
  - Response: o_mispredict=1, redirect=0x500; entry target becomes 0x500.
- Aliasing and same-cycle collision (BTB_ENTRIES=32):
  - Stimulus: taken update at 0x1000 → 0x2000, then fetch 0x1080 (same idx, different tag).
  - Response: miss, next_pc=0x1084.
  - Also: update 0x1080 in the same cycle as fetch 0x1000 → that fetch still returns 0x2000.
- Gating and reset:
  - br_valid=0 or br_update_en=0 with any mismatch → no mispredict, no table or counter change.
  - Assert i_rst_n mid-run → hits vanish immediately, counters read 0.
